// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the RV32M multiply/divide unit.
// Holds funct3 encodings, FSM state encoding and iteration limit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between control path and muldiv_unit.
// master drives the request, slave returns busy/done/result.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_sign.sv
// muldiv_sign: operand magnitudes, result sign and final negate.
// Purely combinational; magnitudes feed an unsigned core datapath.
module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              sgn,
  input  logic [2*XLEN-1:0] res_in,
  input  logic              res_neg,
  output logic [2*XLEN-1:0] res_out
);

  logic a_signed;
  logic b_signed;
  logic sa;
  logic sb;

  // Operand signedness, magnitudes and result sign from funct3
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sa    = a_signed & op_a[XLEN-1];
    sb    = b_signed & op_b[XLEN-1];
    mag_a = sa ? -op_a : op_a;
    mag_b = sb ? -op_b : op_b;
    // remainder follows the dividend, everything else is a xor b
    sgn   = (funct3 == F3_REM) ? sa : (sa ^ sb);
  end

  // Final two's-complement fix-up of the unsigned result
  always_comb begin
    res_out = res_neg ? -res_in : res_in;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Shift-add multiply and restoring divide share one 64-bit register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int W2 = 2 * XLEN;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            sgn;
  logic [W2-1:0]   fix_in;
  logic [W2-1:0]   fix_out;
  logic [W2-1:0]   acc_nx;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_sub;
  logic            div_ge;
  logic [XLEN-1:0] fin;
  logic            accept;
  logic            dz_hit;
  logic            ovf_hit;

  muldiv_sign #(.XLEN(XLEN)) u_sign (
    .funct3  (bus.funct3),
    .op_a    (bus.op_a),
    .op_b    (bus.op_b),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .sgn     (sgn),
    .res_in  (fix_in),
    .res_neg (neg_q),
    .res_out (fix_out)
  );

  // One iteration step; hi half is product/remainder, lo half multiplier/quotient
  always_comb begin
    mul_sum = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, b_q};
    div_ge  = acc_q[W2-1:XLEN-1] >= {1'b0, b_q};
    // low bits of the 33-bit trial difference; exact whenever div_ge
    div_sub = acc_q[W2-2:XLEN-1] - b_q;
    if (f3_q[2]) begin
      acc_nx = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                      : {acc_q[W2-2:0], 1'b0};
    end else begin
      acc_nx = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                        : {1'b0, acc_q[W2-1:1]};
    end
  end

  // Pick the unsigned result field and the half returned after negate
  always_comb begin
    if (!f3_q[2]) begin
      fix_in = acc_nx;
    end else if (f3_q[1]) begin
      fix_in = {{XLEN{1'b0}}, acc_nx[W2-1:XLEN]};
    end else begin
      fix_in = {{XLEN{1'b0}}, acc_nx[XLEN-1:0]};
    end
    if (f3_q == F3_MUL || f3_q[2]) begin
      fin = fix_out[XLEN-1:0];
    end else begin
      fin = fix_out[W2-1:XLEN];
    end
  end

  // Next-state: accept, iterate, special-case shortcut
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    accept   = bus.start && (state_q != S_CALC);
    dz_hit   = bus.funct3[2] && (bus.op_b == '0);
    ovf_hit  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.op_b == '1);
    if (state_q == S_CALC) begin
      acc_d = acc_nx;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == ITER_LAST) begin
        state_d  = S_DONE;
        result_d = fin;
      end
    end else if (accept) begin
      f3_d    = bus.funct3;
      neg_d   = sgn;
      cnt_d   = '0;
      acc_d   = {{XLEN{1'b0}}, mag_a};
      b_d     = mag_b;
      state_d = S_DONE;
      unique case (1'b1)
        dz_hit:  result_d = bus.funct3[1] ? bus.op_a : '1;
        ovf_hit: result_d = bus.funct3[1] ? '0
                          : {1'b1, {(XLEN-1){1'b0}}};
        default: state_d = S_CALC;
      endcase
    end else begin
      state_d = S_IDLE;
    end
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
